// File: rtl/drawing_fs_pkg.sv
// Shared types and helpers for the drawing-engine frame-store responder.
// The byte-merge helper builds the write-back word for read-modify-write.
package drawing_fs_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    RD_WAIT  = 3'd2,
    MERGE_WR = 3'd3,
    ACK      = 3'd4
  } fs_state_t;

  localparam logic [3:0] NBYTE_NONE = 4'hF;
  localparam logic [3:0] NBYTE_ALL  = 4'h0;

  // nbyte is active-low: a 0 bit takes the new byte, a 1 bit keeps the old one.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  nbyte);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (!nbyte[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/drawing_fs_latency_counter.sv
// Read-latency down-counter: loaded when a read is issued, done once the
// RAM data is due on mem_rdata.
module drawing_fs_latency_counter
  import drawing_fs_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam logic [2:0] LOAD_VAL = 3'(MEM_LATENCY - 1);

  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 3'd0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign done = (count == 3'd0);

endmodule

// File: rtl/drawing_frame_store_responder.sv
// Target-side responder for the drawing-engine frame-store bus: one read or
// write per handshake against a shared single-port 32-bit RAM.
//
// state    | meaning
// IDLE     | waiting for a new request
// ISSUE    | request captured, waiting for grant to issue read or write
// RD_WAIT  | read in flight, counting RAM latency
// MERGE_WR | RMW merged word ready, waiting for grant to write back
// ACK      | pulse de_ack on the way back to IDLE
module drawing_frame_store_responder
  import drawing_fs_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int MEM_LATENCY = 2,
  parameter bit HAS_BYTE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic              de_rnw,
  input  logic [31:0]       de_w_data,
  output logic [31:0]       de_r_data,
  input  logic              mem_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  fs_state_t         state;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        nbyte_q;
  logic              rnw_q;
  logic [31:0]       wdata_q;
  logic              needs_rmw;
  logic              lat_load;
  logic              lat_dec;
  logic              lat_done;

  assign needs_rmw = !rnw_q && (HAS_BYTE_EN == 1'b0) && (nbyte_q != NBYTE_ALL);
  assign lat_load  = (state == ISSUE) && mem_gnt && (rnw_q || needs_rmw);
  assign lat_dec   = (state == RD_WAIT);

  drawing_fs_latency_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_latency (
    .clk (clk),
    .rst (rst),
    .load(lat_load),
    .dec (lat_dec),
    .done(lat_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      de_ack    <= 1'b0;
      de_r_data <= 32'h0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      busy      <= 1'b0;
      addr_q    <= '0;
      nbyte_q   <= NBYTE_NONE;
      rnw_q     <= 1'b1;
      wdata_q   <= 32'h0;
    end else begin
      de_ack <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          // de_ack is still high in the ack cycle while the old request is held
          if (de_req && !de_ack) begin
            addr_q  <= de_addr;
            nbyte_q <= de_nbyte;
            rnw_q   <= de_rnw;
            wdata_q <= de_w_data;
            busy    <= 1'b1;
            state   <= (!de_rnw && de_nbyte == NBYTE_NONE) ? ACK : ISSUE;
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            mem_en   <= 1'b1;
            mem_addr <= addr_q;
            if (rnw_q || needs_rmw) begin
              mem_we <= 1'b0;
              mem_be <= 4'hF;
              state  <= RD_WAIT;
            end else begin
              mem_we    <= 1'b1;
              mem_be    <= HAS_BYTE_EN ? ~nbyte_q : 4'hF;
              mem_wdata <= wdata_q;
              state     <= ACK;
            end
          end
        end
        RD_WAIT: begin
          if (lat_done) begin
            if (rnw_q) begin
              de_r_data <= mem_rdata;
              state     <= ACK;
            end else begin
              // mem_wdata is idle while reading, so it holds the merged word
              mem_wdata <= merge_bytes(mem_rdata, wdata_q, nbyte_q);
              state     <= MERGE_WR;
            end
          end
        end
        MERGE_WR: begin
          if (mem_gnt) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b1;
            mem_be   <= 4'hF;
            mem_addr <= addr_q;
            state    <= ACK;
          end
        end
        ACK: begin
          de_ack <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drawing_frame_store_responder.sv
// Self-checking bench: dut_a has RAM byte enables, dut_b uses read-modify-write.
// RAM models return read data one cycle after the mem_en cycle (MEM_LATENCY=2).
module tb_drawing_frame_store_responder;
  import drawing_fs_pkg::*;

  localparam int ADDR_W = 18;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut_a signals
  logic              a_req = 1'b0, a_ack, a_rnw = 1'b1, a_gnt = 1'b1;
  logic [ADDR_W-1:0] a_addr = '0, a_mem_addr;
  logic [3:0]        a_nbyte = 4'hF, a_mem_be;
  logic [31:0]       a_wdata = 32'h0, a_rdata, a_mem_wdata, a_rd_pipe = 32'h0;
  logic              a_mem_en, a_mem_we, a_busy;
  // dut_b signals
  logic              b_req = 1'b0, b_ack, b_rnw = 1'b1, b_gnt = 1'b1;
  logic [ADDR_W-1:0] b_addr = '0, b_mem_addr;
  logic [3:0]        b_nbyte = 4'hF, b_mem_be;
  logic [31:0]       b_wdata = 32'h0, b_rdata, b_mem_wdata, b_rd_pipe = 32'h0;
  logic              b_mem_en, b_mem_we, b_busy;

  logic [31:0] ram_a [0:(1<<ADDR_W)-1];
  logic [31:0] ram_b [0:(1<<ADDR_W)-1];
  logic [31:0] ref_a [0:15];
  logic [31:0] sb_q [$];

  int a_en_cnt = 0, a_ack_cnt = 0, b_en_cnt = 0, b_rd_cnt = 0;
  logic              a_last_we = 1'b0, b_last_we = 1'b0;
  logic [3:0]        a_last_be = 4'h0, b_last_be = 4'h0;
  logic [ADDR_W-1:0] a_last_addr = '0;
  logic [31:0]       b_last_wdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] a_last_read = 32'h0;

  drawing_frame_store_responder #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT), .HAS_BYTE_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .de_req(a_req), .de_ack(a_ack), .de_addr(a_addr),
    .de_nbyte(a_nbyte), .de_rnw(a_rnw), .de_w_data(a_wdata), .de_r_data(a_rdata),
    .mem_gnt(a_gnt), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(a_rd_pipe), .busy(a_busy));

  drawing_frame_store_responder #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT), .HAS_BYTE_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .de_req(b_req), .de_ack(b_ack), .de_addr(b_addr),
    .de_nbyte(b_nbyte), .de_rnw(b_rnw), .de_w_data(b_wdata), .de_r_data(b_rdata),
    .mem_gnt(b_gnt), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rdata(b_rd_pipe), .busy(b_busy));

  always @(posedge clk) begin
    if (a_mem_en) begin
      a_en_cnt    <= a_en_cnt + 1;
      a_last_we   <= a_mem_we;
      a_last_be   <= a_mem_be;
      a_last_addr <= a_mem_addr;
      if (a_mem_we) begin
        for (int i = 0; i < 4; i++)
          if (a_mem_be[i]) ram_a[a_mem_addr][8*i +: 8] = a_mem_wdata[8*i +: 8];
      end else begin
        a_rd_pipe <= ram_a[a_mem_addr];
      end
    end
    if (a_ack) a_ack_cnt <= a_ack_cnt + 1;
  end

  always @(posedge clk) begin
    if (b_mem_en) begin
      b_en_cnt     <= b_en_cnt + 1;
      b_last_we    <= b_mem_we;
      b_last_be    <= b_mem_be;
      b_last_wdata <= b_mem_wdata;
      if (b_mem_we) begin
        for (int i = 0; i < 4; i++)
          if (b_mem_be[i]) ram_b[b_mem_addr][8*i +: 8] = b_mem_wdata[8*i +: 8];
      end else begin
        b_rd_cnt  <= b_rd_cnt + 1;
        b_rd_pipe <= ram_b[b_mem_addr];
      end
    end
  end

  task automatic drive_a(input logic rnw, input logic [ADDR_W-1:0] addr,
                         input logic [3:0] nb, input logic [31:0] wd);
    a_req = 1'b1; a_rnw = rnw; a_addr = addr; a_nbyte = nb; a_wdata = wd;
  endtask

  // Called just after a posedge; lat 0 is the cycle the request was driven in.
  task automatic wait_ack_a(output int lat, output bit seen);
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_ack) begin seen = 1'b1; lat = i; break; end
    end
  endtask

  task automatic wait_ack_b(output int lat, output bit seen);
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_ack) begin seen = 1'b1; lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_ack !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_ack_busy: got ack=%b busy=%b, want 0 0", a_ack, a_busy); end
    n_cmp++; if (a_mem_en !== 1'b0 || a_mem_we !== 1'b0 || a_mem_be !== 4'h0) begin n_bad++; $display("FAIL reset_mem_ctl: got en=%b we=%b be=%h, want 0 0 0", a_mem_en, a_mem_we, a_mem_be); end
    n_cmp++; if (a_rdata !== 32'h0 || a_mem_addr !== '0 || a_mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, want 0", a_rdata, a_mem_addr, a_mem_wdata); end
    n_cmp++; if (dut_a.state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d, want %0d", dut_a.state, IDLE); end
    n_cmp++; if (b_ack !== 1'b0 || b_busy !== 1'b0 || b_mem_en !== 1'b0 || b_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_dut_b: got ack=%b busy=%b en=%b rdata=%h, want 0", b_ack, b_busy, b_mem_en, b_rdata); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_read();
    int lat; bit seen;
    ram_a[18'h00010] = 32'hDEADBEEF;
    @(posedge clk); #1 drive_a(1'b1, 18'h00010, 4'h0, 32'h0);
    wait_ack_a(lat, seen);
    n_cmp++; if (!seen || lat != 3 + LAT) begin n_bad++; $display("FAIL read_latency: got %0d (seen=%b), want %0d", lat, seen, 3 + LAT); end
    n_cmp++; if (a_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data: got %h, want DEADBEEF", a_rdata); end
    @(posedge clk); #1 a_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_rdata !== 32'hDEADBEEF || a_busy !== 1'b0) begin n_bad++; $display("FAIL read_hold: got rdata=%h busy=%b, want DEADBEEF 0", a_rdata, a_busy); end
    a_last_read = 32'hDEADBEEF;
  endtask

  task automatic test_partial_write();
    int lat; bit seen; int en0;
    ram_a[18'h3FFFF] = 32'h01020304;
    en0 = a_en_cnt;
    @(posedge clk); #1 drive_a(1'b0, 18'h3FFFF, 4'b0101, 32'hAABBCCDD);
    wait_ack_a(lat, seen);
    n_cmp++; if (!seen || lat != 3) begin n_bad++; $display("FAIL pwrite_latency: got %0d (seen=%b), want 3", lat, seen); end
    @(posedge clk); #1 a_req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_en_cnt - en0 != 1) begin n_bad++; $display("FAIL pwrite_en_pulses: got %0d, want 1", a_en_cnt - en0); end
    n_cmp++; if (a_last_we !== 1'b1 || a_last_be !== 4'b1010 || a_last_addr !== 18'h3FFFF) begin n_bad++; $display("FAIL pwrite_access: got we=%b be=%b addr=%h, want 1 1010 3ffff", a_last_we, a_last_be, a_last_addr); end
    n_cmp++; if (ram_a[18'h3FFFF] !== 32'hAA02CC04) begin n_bad++; $display("FAIL pwrite_ram: got %h, want AA02CC04", ram_a[18'h3FFFF]); end
    n_cmp++; if (a_rdata !== a_last_read) begin n_bad++; $display("FAIL pwrite_rdata_kept: got %h, want %h", a_rdata, a_last_read); end
  endtask

  task automatic test_nbyte_none();
    int lat; bit seen; int en0;
    ram_a[18'h00005] = 32'h55555555;
    en0 = a_en_cnt;
    @(posedge clk); #1 drive_a(1'b0, 18'h00005, 4'hF, 32'h12345678);
    wait_ack_a(lat, seen);
    n_cmp++; if (!seen || lat != 2) begin n_bad++; $display("FAIL none_latency: got %0d (seen=%b), want 2", lat, seen); end
    @(posedge clk); #1 a_req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_en_cnt != en0 || ram_a[18'h00005] !== 32'h55555555) begin n_bad++; $display("FAIL none_no_access: got pulses=%0d ram=%h, want 0 55555555", a_en_cnt - en0, ram_a[18'h00005]); end
  endtask

  task automatic test_grant_stall();
    int lat; bit seen; int en_bad; int busy_bad;
    en_bad = 0; busy_bad = 0;
    ram_a[18'h00020] = 32'hCAFEF00D;
    @(posedge clk); #1 a_gnt = 1'b0; drive_a(1'b1, 18'h00020, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (a_mem_en !== 1'b0) en_bad++;
      if (a_busy !== 1'b1) busy_bad++;
    end
    n_cmp++; if (en_bad != 0) begin n_bad++; $display("FAIL stall_mem_en: got %0d cycles with mem_en, want 0", en_bad); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL stall_busy: got %0d cycles without busy, want 0", busy_bad); end
    @(posedge clk); #1 a_gnt = 1'b1;
    wait_ack_a(lat, seen);
    n_cmp++; if (!seen || lat != 2 + LAT) begin n_bad++; $display("FAIL stall_latency: got %0d (seen=%b), want %0d", lat, seen, 2 + LAT); end
    n_cmp++; if (a_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL stall_data: got %h, want CAFEF00D", a_rdata); end
    a_last_read = 32'hCAFEF00D;
    @(posedge clk); #1 a_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; bit seen; int ack0; int d; int done_n;
    logic rnw; logic [3:0] nb; logic [31:0] wd; logic [ADDR_W-1:0] addr; logic [31:0] exp_v; logic [31:0] got_v;
    for (int i = 0; i < 16; i++) begin
      ref_a[i] = $urandom;
      ram_a[i] = ref_a[i];
    end
    sb_q.delete();
    ack0 = a_ack_cnt; done_n = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 100; k++) begin
      rnw  = 1'($urandom_range(0, 1));
      addr = ADDR_W'($urandom_range(0, 15));
      nb   = 4'($urandom_range(0, 15));
      wd   = $urandom;
      if (rnw) begin
        exp_v = ref_a[addr[3:0]];
        a_last_read = exp_v;
      end else begin
        for (int b = 0; b < 4; b++) if (!nb[b]) ref_a[addr[3:0]][8*b +: 8] = wd[8*b +: 8];
        exp_v = a_last_read;
      end
      sb_q.push_back(exp_v);
      drive_a(rnw, addr, nb, wd);
      wait_ack_a(lat, seen);
      if (!seen) begin
        n_cmp++; n_bad++; $display("FAIL b2b_timeout: request %0d got no ack, want ack", k);
        break;
      end
      got_v = sb_q.pop_front();
      n_cmp++; if (a_rdata !== got_v) begin n_bad++; $display("FAIL b2b_rdata: req %0d got %h, want %h", k, a_rdata, got_v); end
      done_n++;
      @(posedge clk); #1;
      d = $urandom_range(0, 4);
      if (d > 0) begin
        a_req = 1'b0;
        repeat (d) @(posedge clk);
        #1;
      end
    end
    a_req = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (a_ack_cnt - ack0 != done_n || done_n != 100) begin n_bad++; $display("FAIL b2b_ack_count: got %0d acks for %0d requests, want 100", a_ack_cnt - ack0, done_n); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (ram_a[i] !== ref_a[i]) begin n_bad++; $display("FAIL b2b_ram: addr %0d got %h, want %h", i, ram_a[i], ref_a[i]); end
    end
  endtask

  task automatic test_rmw();
    int lat; bit seen; int en0; int rd0;
    ram_b[18'h00100] = 32'h11223344;
    en0 = b_en_cnt; rd0 = b_rd_cnt;
    @(posedge clk); #1 b_req = 1'b1; b_rnw = 1'b0; b_addr = 18'h00100; b_nbyte = 4'b1100; b_wdata = 32'hAABBCCDD;
    wait_ack_b(lat, seen);
    n_cmp++; if (!seen || lat != 4 + LAT) begin n_bad++; $display("FAIL rmw_latency: got %0d (seen=%b), want %0d", lat, seen, 4 + LAT); end
    @(posedge clk); #1 b_req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (b_en_cnt - en0 != 2 || b_rd_cnt - rd0 != 1) begin n_bad++; $display("FAIL rmw_pulses: got en=%0d reads=%0d, want 2 1", b_en_cnt - en0, b_rd_cnt - rd0); end
    n_cmp++; if (b_last_we !== 1'b1 || b_last_be !== 4'hF || b_last_wdata !== 32'h1122CCDD) begin n_bad++; $display("FAIL rmw_write: got we=%b be=%h data=%h, want 1 f 1122CCDD", b_last_we, b_last_be, b_last_wdata); end
    n_cmp++; if (ram_b[18'h00100] !== 32'h1122CCDD) begin n_bad++; $display("FAIL rmw_ram: got %h, want 1122CCDD", ram_b[18'h00100]); end
    n_cmp++; if (b_rdata !== 32'h0) begin n_bad++; $display("FAIL rmw_rdata_kept: got %h, want 0", b_rdata); end
  endtask

  task automatic test_reset_mid();
    int lat; bit seen; int ack0;
    ram_a[18'h00030] = 32'h0BADF00D;
    @(posedge clk); #1 drive_a(1'b1, 18'h00030, 4'h0, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (dut_a.state !== RD_WAIT) begin n_bad++; $display("FAIL rstmid_pre_state: got %0d, want %0d", dut_a.state, RD_WAIT); end
    rst = 1'b1; a_req = 1'b0;
    ack0 = a_ack_cnt;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (a_ack !== 1'b0 || a_mem_en !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_outputs: got ack=%b en=%b busy=%b, want 0 0 0", a_ack, a_mem_en, a_busy); end
    n_cmp++; if (dut_a.state !== IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d, want %0d", dut_a.state, IDLE); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (a_ack_cnt != ack0) begin n_bad++; $display("FAIL rstmid_no_ack: got %0d acks, want 0", a_ack_cnt - ack0); end
    @(posedge clk); #1 drive_a(1'b1, 18'h00030, 4'h0, 32'h0);
    wait_ack_a(lat, seen);
    n_cmp++; if (!seen || lat != 3 + LAT || a_rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL rstmid_after: got lat=%0d seen=%b data=%h, want %0d 1 0BADF00D", lat, seen, a_rdata, 3 + LAT); end
    @(posedge clk); #1 a_req = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_partial_write();
    test_nbyte_none();
    test_grant_stall();
    test_back_to_back();
    test_rmw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
